// File: rtl/spi_slave_param.sv
// SPI slave front end: deserialises command+payload frames from MOSI and, for
// read-data frames, serialises the RAM response onto MISO with a bounded wait.
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MOSI,
    input  logic              SS_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              frame_err
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int TO_W    = $clog2(TX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TX_TIMEOUT);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    // Progress inside a routed frame: receiving, waiting for RAM, driving MISO, holding.
    typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_SHIFT, PH_DONE} phase_t;

    state_t            state_reg, state_next;
    phase_t            phase_reg, phase_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [TO_W-1:0]   tout_cnt_reg, tout_cnt_next;
    logic [DATA_W:0]   shift_reg, shift_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic              rd_addr_seen_reg, rd_addr_seen_next;
    logic              miso_reg, miso_next;
    logic              rx_valid_reg, rx_valid_next;
    logic [DATA_W+1:0] rx_data_reg, rx_data_next;
    logic              frame_err_reg, frame_err_next;

    always_comb begin
        state_next        = state_reg;
        phase_next        = phase_reg;
        bit_cnt_next      = bit_cnt_reg;
        tout_cnt_next     = tout_cnt_reg;
        shift_next        = shift_reg;
        tx_shift_next     = tx_shift_reg;
        rd_addr_seen_next = rd_addr_seen_reg;
        miso_next         = miso_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        frame_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    shift_next   = {shift_reg[DATA_W-1:0], MOSI};
                    bit_cnt_next = CNT_W'(1);
                    if (!MOSI)                 state_next = WRITE;
                    else if (rd_addr_seen_reg) state_next = READ_DATA;
                    else                       state_next = READ_ADD;
                end
            end
            default: begin
                case (phase_reg)
                    PH_RX: begin
                        // The last bit completes the frame even if SS_n rises on that edge.
                        if (bit_cnt_reg == LAST_BIT) begin
                            rx_valid_next = 1'b1;
                            rx_data_next  = {shift_reg, MOSI};
                            tout_cnt_next = '0;
                            if (state_reg == READ_ADD) rd_addr_seen_next = 1'b1;
                            phase_next = (state_reg == READ_DATA) ? PH_WAIT : PH_DONE;
                            if (SS_n) state_next = IDLE;
                        end else if (SS_n) begin
                            frame_err_next = 1'b1;
                            state_next     = IDLE;
                        end else begin
                            shift_next   = {shift_reg[DATA_W-1:0], MOSI};
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                    PH_WAIT: begin
                        // Count 0 marks the rx_valid cycle, which is outside the wait window.
                        if (SS_n) begin
                            state_next = IDLE;
                        end else if (tout_cnt_reg == '0) begin
                            tout_cnt_next = TO_W'(1);
                        end else if (tx_valid) begin
                            miso_next     = tx_data[DATA_W-1];
                            tx_shift_next = tx_data << 1;
                            bit_cnt_next  = CNT_W'(1);
                            phase_next    = PH_SHIFT;
                        end else if (tout_cnt_reg == TO_LIMIT) begin
                            frame_err_next    = 1'b1;
                            rd_addr_seen_next = 1'b0;
                            phase_next        = PH_DONE;
                        end else begin
                            tout_cnt_next = tout_cnt_reg + 1'b1;
                        end
                    end
                    PH_SHIFT: begin
                        if (bit_cnt_reg == TX_LAST) begin
                            miso_next         = 1'b0;
                            rd_addr_seen_next = 1'b0;
                            phase_next        = PH_DONE;
                            if (SS_n) state_next = IDLE;
                        end else if (SS_n) begin
                            frame_err_next    = 1'b1;
                            rd_addr_seen_next = 1'b0;
                            state_next        = IDLE;
                        end else begin
                            miso_next     = tx_shift_reg[DATA_W-1];
                            tx_shift_next = tx_shift_reg << 1;
                            bit_cnt_next  = bit_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        if (SS_n) state_next = IDLE;
                    end
                endcase
            end
        endcase

        // Any return to IDLE clears the per-frame counters on that same edge.
        if (state_next == IDLE) begin
            phase_next    = PH_RX;
            bit_cnt_next  = '0;
            tout_cnt_next = '0;
            miso_next     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            phase_reg        <= PH_RX;
            bit_cnt_reg      <= '0;
            tout_cnt_reg     <= '0;
            shift_reg        <= '0;
            tx_shift_reg     <= '0;
            rd_addr_seen_reg <= 1'b0;
            miso_reg         <= 1'b0;
            rx_valid_reg     <= 1'b0;
            rx_data_reg      <= '0;
            frame_err_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            bit_cnt_reg      <= bit_cnt_next;
            tout_cnt_reg     <= tout_cnt_next;
            shift_reg        <= shift_next;
            tx_shift_reg     <= tx_shift_next;
            rd_addr_seen_reg <= rd_addr_seen_next;
            miso_reg         <= miso_next;
            rx_valid_reg     <= rx_valid_next;
            rx_data_reg      <= rx_data_next;
            frame_err_reg    <= frame_err_next;
        end
    end

    assign MISO      = miso_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_data   = rx_data_reg;
    assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised bench for spi_slave_param: an 8-bit instance exercised frame by frame against
// a transaction-level expectation, plus a 16-bit instance for reset-mid-frame behaviour.
module tb_spi_slave_param;
    localparam int DW  = 8;
    localparam int TO  = 16;
    localparam int DW2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, mosi, ss_n, tx_valid, miso, rx_valid, frame_err;
    logic [DW-1:0] tx_data;
    logic [DW+1:0] rx_data;

    logic           rst2, mosi2, ss2, tx_valid2, miso2, rx_valid2, frame_err2;
    logic [DW2-1:0] tx_data2;
    logic [DW2+1:0] rx_data2;

    spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .MOSI(mosi), .SS_n(ss_n), .tx_valid(tx_valid),
        .tx_data(tx_data), .MISO(miso), .rx_valid(rx_valid), .rx_data(rx_data),
        .frame_err(frame_err)
    );

    spi_slave_param #(.DATA_W(DW2), .TX_TIMEOUT(TO)) u_dut16 (
        .clk(clk), .rst(rst2), .MOSI(mosi2), .SS_n(ss2), .tx_valid(tx_valid2),
        .tx_data(tx_data2), .MISO(miso2), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .frame_err(frame_err2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit seen_m   = 1'b0;  // a read-address frame completed since the last read-data frame

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Entry/exit: SS_n high, #1 after a rising edge. nb<10 aborts after nb bits; d is the
    // tx_valid delay in cycles after the rx_valid cycle (-1 = never); abort_at>0 raises SS_n
    // abort_at cycles after tx_valid was taken; ss_last raises SS_n together with the last bit.
    task automatic run_frame(input logic [9:0] f, input int nb, input int d,
                             input logic [DW-1:0] v, input int abort_at, input bit ss_last);
        bit is_rd;
        ss_n = 1'b0;
        mosi = 1'($urandom);
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            if (k == nb) begin
                ss_n = 1'b1;
                @(posedge clk); #1;
                check_val("abort_err", frame_err, 1);
                check_val("abort_no_valid", rx_valid, 0);
                @(posedge clk); #1;
                check_val("abort_err_once", frame_err, 0);
                $display("frame %03h aborted after %0d bits", f, nb);
                return;
            end
            mosi = f[9-k];
            if (k == 9 && ss_last) ss_n = 1'b1;
            @(posedge clk); #1;
            if (k < 9) check_val("rx_early", rx_valid, 0);
        end
        check_val("rx_valid", rx_valid, 1);
        check_val("rx_data", rx_data, 32'(f));
        check_val("rx_no_err", frame_err, 0);
        is_rd = f[9] && seen_m;
        if (f[9] && !seen_m) seen_m = 1'b1;

        if (!is_rd) begin
            for (int n = 1; n <= 4; n++) begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = DW'($urandom);
                @(posedge clk); #1;
                check_val("wr_miso_zero", miso, 0);
                check_val("wr_no_err", frame_err, 0);
            end
        end else begin
            int  tv, win_end, abs_abort;
            bit  got, exp_fe;
            logic exp_miso;
            got       = (d >= 1 && d <= TO);
            tv        = 1 + d;
            win_end   = got ? tv : TO + 1;
            abs_abort = (got && abort_at > 0) ? tv + abort_at : 0;
            for (int n = 1; n <= 28; n++) begin
                if (n >= 2) begin
                    exp_fe = (abs_abort > 0) ? (n == abs_abort + 1) : (!got && n == TO + 2);
                    exp_miso = (got && n > tv && n <= tv + DW && (abs_abort == 0 || n <= abs_abort))
                               ? v[DW-(n-tv)] : 1'b0;
                    check_val("rd_miso", miso, 32'(exp_miso));
                    check_val("rd_err", frame_err, 32'(exp_fe));
                end
                tx_valid = (n == tv) || ((n == 1 || n > win_end) && $urandom_range(0, 2) == 0);
                tx_data  = (n == tv) ? v : DW'($urandom);
                if (n == abs_abort) ss_n = 1'b1;
                @(posedge clk); #1;
            end
            seen_m = 1'b0;
        end
        tx_valid = 1'b0;
        if (!ss_n) begin
            ss_n = 1'b1;
            @(posedge clk); #1;
            check_val("close_no_err", frame_err, 0);
        end
        check_val("rx_hold", rx_data, 32'(f));
        $display("frame %03h rd=%0d d=%0d v=%02h abort_at=%0d ss_last=%0d", f, is_rd, d, v, abort_at, ss_last);
    endtask

    task automatic frame16(input logic [17:0] f, input int rst_at);
        ss2 = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 18; k++) begin
            mosi2 = f[17-k];
            if (k == rst_at) rst2 = 1'b1;
            @(posedge clk); #1;
            if (k == rst_at) begin
                rst2 = 1'b0;
                ss2  = 1'b1;
                check_val("w16_rst_data", rx_data2, 0);
                check_val("w16_rst_valid", rx_valid2, 0);
                check_val("w16_rst_err", frame_err2, 0);
                check_val("w16_rst_miso", miso2, 0);
                @(posedge clk); #1;
                check_val("w16_rst_no_err", frame_err2, 0);
                $display("frame16 %05h reset at bit %0d", f, rst_at);
                return;
            end
            if (k < 17) check_val("w16_rx_early", rx_valid2, 0);
        end
        check_val("w16_rx_valid", rx_valid2, 1);
        check_val("w16_rx_data", rx_data2, 32'(f));
        ss2 = 1'b1;
        @(posedge clk); #1;
        check_val("w16_no_err", frame_err2, 0);
        $display("frame16 %05h received", f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] f;
        int r;
        rst = 1'b1; rst2 = 1'b1;
        ss_n = 1'b1; ss2 = 1'b1;
        mosi = 1'b0; mosi2 = 1'b0;
        tx_valid = 1'b0; tx_valid2 = 1'b0;
        tx_data = '0; tx_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_miso", miso, 0);
        check_val("rst_valid", rx_valid, 0);
        check_val("rst_data", rx_data, 0);
        check_val("rst_err", frame_err, 0);
        check_val("rst16_data", rx_data2, 0);
        check_val("rst16_err", frame_err2, 0);
        rst = 1'b0; rst2 = 1'b0;
        @(posedge clk); #1;

        run_frame(10'h0A5, 10, 0, 8'h00, 0, 0);            // plain write-address frame
        run_frame(10'h203, 10, 0, 8'h00, 0, 0);            // read address
        run_frame({2'b11, 8'($urandom)}, 10, 3, 8'hC3, 0, 0);
        run_frame({2'b11, 8'($urandom)}, 10, 5, 8'h5A, 0, 0);  // routed as read address
        run_frame({2'b11, 8'($urandom)}, 10, 5, 8'h96, 0, 0);  // routed as read data
        run_frame(10'h2F0, 10, 0, 8'h00, 0, 0);
        run_frame({2'b11, 8'($urandom)}, 10, -1, 8'hFF, 0, 0); // timeout
        run_frame(10'h155, 5, 0, 8'h00, 0, 0);             // abort after 5 bits
        run_frame(10'h1F0, 10, 0, 8'h00, 0, 0);
        run_frame(10'h2AA, 10, 0, 8'h00, 0, 0);
        run_frame({2'b11, 8'($urandom)}, 10, 2, 8'hB7, 4, 0);  // abort while shifting MISO
        run_frame(10'h0E1, 10, 0, 8'h00, 0, 1);            // SS_n rises with the last bit
        run_frame(10'h300, 0, 0, 8'h00, 0, 0);             // abort in command bit

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            f = 10'($urandom);
            if (r == 0) begin
                run_frame(f, $urandom_range(0, 8), 0, 8'h00, 0, 0);
            end else if (r == 1) begin
                f[9] = 1'b0;
                run_frame(f, 10, 0, 8'h00, 0, 1);
            end else begin
                run_frame(f, 10, $urandom_range(0, 20), DW'($urandom),
                          (r == 2) ? $urandom_range(1, 7) : 0, 0);
            end
        end

        frame16(18'($urandom) | 18'h1, -1);
        frame16(18'($urandom), 9);
        for (int i = 0; i < 3; i++) frame16(18'($urandom), -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
